// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared funct3 codes, FSM state encodings and port ids for the memory arbiter.
package mem_arbiter_ctrl_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;

  typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StErr} state_e;

  typedef enum logic {PortFetch, PortData} port_e;

  function automatic logic type_unsupported(input logic we, input logic [2:0] ftype);
    if (we) return !(ftype inside {STORE_SB, STORE_SH, STORE_SW});
    return ftype inside {3'b011, 3'b110, 3'b111};
  endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Fetch, load/store and memory-array signals of the arbiter, grouped per side.
interface mem_arbiter_ctrl_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [31:0]       i_req_addr;
  logic              i_resp_valid;
  logic [31:0]       i_resp_data;
  logic              i_resp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [2:0]        d_req_type;
  logic [31:0]       d_req_addr;
  logic [31:0]       d_req_wdata;
  logic              d_resp_valid;
  logic [31:0]       d_resp_data;
  logic              d_resp_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    input  d_req_valid, d_req_we, d_req_type, d_req_addr, d_req_wdata,
    output d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    output d_req_valid, d_req_we, d_req_type, d_req_addr, d_req_wdata,
    input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_lane_fmt.sv
// Little-endian lane logic: load extraction/extension, store merge and alignment check.
module mem_lane_fmt
  import mem_arbiter_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  ftype,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic        misalign
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[8*lane +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];

    unique case (ftype)
      LOAD_LB:  load_val = {{24{byte_v[7]}}, byte_v};
      LOAD_LBU: load_val = {24'b0, byte_v};
      LOAD_LH:  load_val = {{16{half_v[15]}}, half_v};
      LOAD_LHU: load_val = {16'b0, half_v};
      default:  load_val = word;
    endcase

    store_word = word;
    unique case (ftype[1:0])
      2'b00: store_word[8*lane +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase

    misalign = ((ftype[1:0] == 2'b01) && lane[0]) || ((ftype[1:0] == 2'b10) && (lane != 2'b00));
  end
endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates fetch and load/store ports onto one single-port synchronous memory,
// sequencing word reads, sub-word loads, read-modify-write stores and faults.
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input logic               clk,
  input logic               rst,
  mem_arbiter_ctrl_if.slave bus
);
  state_e             state_q, state_d;
  port_e              last_q, last_d, src_q, src_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;
  logic [2:0]         type_q, type_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               i_valid_q, i_valid_d, i_err_q, i_err_d;
  logic               d_valid_q, d_valid_d, d_err_q, d_err_d;
  logic [31:0]        i_data_q, i_data_d, d_data_q, d_data_d;

  logic               idle, grant_data, grant_fetch, fault;
  logic [31:0]        req_addr;
  logic [2:0]         req_type;
  logic               req_we;
  logic [1:0]         fmt_lane;
  logic [2:0]         fmt_type;
  logic [31:0]        load_val, store_word;
  logic               misalign;

  assign idle        = (state_q == StIdle);
  assign grant_data  = bus.d_req_valid && (!bus.i_req_valid || (last_q == PortFetch));
  assign grant_fetch = bus.i_req_valid && !grant_data;
  // Fetches are classified and formatted as LW so one alignment rule covers both ports.
  assign req_addr    = grant_data ? bus.d_req_addr : bus.i_req_addr;
  assign req_type    = grant_data ? bus.d_req_type : LOAD_LW;
  assign req_we      = grant_data && bus.d_req_we;
  assign fmt_lane    = idle ? req_addr[1:0] : addr_q[1:0];
  assign fmt_type    = idle ? req_type : type_q;
  assign fault       = (|req_addr[31:ADDR_W+2]) || misalign ||
                       (grant_data && type_unsupported(req_we, req_type));

  mem_lane_fmt u_lane_fmt (
    .word       (bus.mem_rdata),
    .lane       (fmt_lane),
    .ftype      (fmt_type),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word),
    .misalign   (misalign)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    src_d     = src_q;
    addr_d    = addr_q;
    type_d    = type_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_valid_d = 1'b0;
    i_data_d  = i_data_q;
    i_err_d   = i_err_q;
    d_valid_d = 1'b0;
    d_data_d  = d_data_q;
    d_err_d   = d_err_q;

    unique case (state_q)
      StIdle: begin
        if (grant_fetch || grant_data) begin
          src_d   = grant_data ? PortData : PortFetch;
          last_d  = src_d;
          addr_d  = req_addr[ADDR_W+1:0];
          type_d  = req_type;
          we_d    = req_we;
          wdata_d = bus.d_req_wdata;
          if (fault)                               state_d = StErr;
          else if (req_we && req_type == STORE_SW) state_d = StWr;
          else                                     state_d = StRd;
        end
      end
      StRd: state_d = StRdw;
      StRdw: begin
        if (we_q) begin
          wdata_d = store_word;
          state_d = StWr;
        end else begin
          if (src_q == PortFetch) begin
            i_valid_d = 1'b1;
            i_data_d  = load_val;
            i_err_d   = 1'b0;
          end else begin
            d_valid_d = 1'b1;
            d_data_d  = load_val;
            d_err_d   = 1'b0;
          end
          state_d = StIdle;
        end
      end
      StWr: begin
        d_valid_d = 1'b1;
        d_data_d  = '0;
        d_err_d   = 1'b0;
        state_d   = StIdle;
      end
      StErr: begin
        if (src_q == PortFetch) begin
          i_valid_d = 1'b1;
          i_data_d  = '0;
          i_err_d   = 1'b1;
        end else begin
          d_valid_d = 1'b1;
          d_data_d  = '0;
          d_err_d   = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= PortFetch;
      src_q     <= PortFetch;
      addr_q    <= '0;
      type_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_valid_q <= 1'b0;
      i_data_q  <= '0;
      i_err_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      src_q     <= src_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_valid_q <= i_valid_d;
      i_data_q  <= i_data_d;
      i_err_q   <= i_err_d;
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
      d_err_q   <= d_err_d;
    end
  end

  assign bus.i_req_ready  = idle && grant_fetch;
  assign bus.d_req_ready  = idle && grant_data;
  assign bus.i_resp_valid = i_valid_q;
  assign bus.i_resp_data  = i_data_q;
  assign bus.i_resp_err   = i_err_q;
  assign bus.d_resp_valid = d_valid_q;
  assign bus.d_resp_data  = d_data_q;
  assign bus.d_resp_err   = d_err_q;
  assign bus.mem_en       = (state_q == StRd) || (state_q == StWr);
  assign bus.mem_we       = (state_q == StWr);
  assign bus.mem_addr     = addr_q[ADDR_W+1:2];
  assign bus.mem_wdata    = wdata_q;
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: transaction-level model checked every cycle plus directed vectors.
module tb_mem_arbiter_ctrl;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned Words  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_arbiter_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory array with 1-cycle synchronous read and a backdoor preload port.
  logic [31:0]       mem [Words];
  logic              bd_en = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [31:0]       bd_data = '0;

  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic [31:0] load_value(input logic [31:0] w, input int unsigned lane,
                                             input logic [2:0] t);
    logic [31:0] b, h;
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * (lane / 2))) & 32'hFFFF;
    case (t)
      3'd0:    return (b >= 128) ? (32'hFFFFFF00 | b) : b;
      3'd1:    return (h >= 32768) ? (32'hFFFF0000 | h) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input int unsigned lane,
                                        input logic [2:0] t, input logic [31:0] wd);
    logic [31:0] mask, shifted;
    if (t == 3'd0) begin
      mask    = 32'hFF << (8 * lane);
      shifted = wd << (8 * lane);
    end else begin
      mask    = 32'hFFFF << (16 * (lane / 2));
      shifted = wd << (16 * (lane / 2));
    end
    return (w & ~mask) | (shifted & mask);
  endfunction

  // Transaction-level model: one outstanding request, expectations scheduled by cycle number.
  int                free_cyc = 0;
  int                resp_cyc = -1;
  int                rd_cyc = -1;
  int                wr_cyc = -1;
  logic              m_last_data = 1'b0;
  logic              exp_src = 1'b0;
  logic [31:0]       exp_data = '0;
  logic              exp_err = 1'b0;
  logic [31:0]       exp_i_data = '0, exp_d_data = '0;
  logic              exp_i_err = 1'b0, exp_d_err = 1'b0;
  int unsigned       exp_widx = 0;
  logic [31:0]       exp_wword = '0;

  always @(negedge clk) begin : model
    logic        g_data, g_fetch, we, bad;
    logic [31:0] a, w, wd;
    logic [2:0]  t;
    int unsigned size, lat;
    if (rst) begin
      free_cyc    = 0;
      resp_cyc    = -1;
      rd_cyc      = -1;
      wr_cyc      = -1;
      m_last_data = 1'b0;
      exp_i_data  = '0;
      exp_d_data  = '0;
      exp_i_err   = 1'b0;
      exp_d_err   = 1'b0;
      check_b("rst_i_resp_valid", bus.i_resp_valid, 1'b0);
      check_b("rst_d_resp_valid", bus.d_resp_valid, 1'b0);
      check_b("rst_mem_en", bus.mem_en, 1'b0);
      check_b("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_i_resp_data", bus.i_resp_data, 32'h0);
      check("rst_d_resp_data", bus.d_resp_data, 32'h0);
    end else begin
      if (cyc == resp_cyc) begin
        if (exp_src) begin
          exp_d_data = exp_data;
          exp_d_err  = exp_err;
        end else begin
          exp_i_data = exp_data;
          exp_i_err  = exp_err;
        end
      end
      check_b("i_resp_valid", bus.i_resp_valid, (cyc == resp_cyc) && !exp_src);
      check_b("d_resp_valid", bus.d_resp_valid, (cyc == resp_cyc) && exp_src);
      check("i_resp_data", bus.i_resp_data, exp_i_data);
      check_b("i_resp_err", bus.i_resp_err, exp_i_err);
      check("d_resp_data", bus.d_resp_data, exp_d_data);
      check_b("d_resp_err", bus.d_resp_err, exp_d_err);
      check_b("mem_en", bus.mem_en, (cyc == rd_cyc) || (cyc == wr_cyc));
      check_b("mem_we", bus.mem_we, cyc == wr_cyc);
      if (cyc == rd_cyc || cyc == wr_cyc) check("mem_addr", 32'(bus.mem_addr), exp_widx);
      if (cyc == wr_cyc) check("mem_wdata", bus.mem_wdata, exp_wword);

      g_data  = 1'b0;
      g_fetch = 1'b0;
      if (cyc >= free_cyc) begin
        if (bus.d_req_valid && (!bus.i_req_valid || !m_last_data)) g_data = 1'b1;
        else if (bus.i_req_valid) g_fetch = 1'b1;
      end
      check_b("i_req_ready", bus.i_req_ready, g_fetch);
      check_b("d_req_ready", bus.d_req_ready, g_data);

      if (g_data || g_fetch) begin
        m_last_data = g_data;
        a    = g_data ? bus.d_req_addr : bus.i_req_addr;
        we   = g_data && bus.d_req_we;
        t    = g_data ? bus.d_req_type : 3'd2;
        wd   = bus.d_req_wdata;
        size = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
        bad  = (a >= Words * 4) || ((a % size) != 0) ||
               (g_data && (we ? (t > 3'd2) : (t == 3'd3 || t >= 3'd6)));
        exp_src  = g_data;
        exp_widx = (a / 4) % Words;
        w        = mem[exp_widx];
        rd_cyc   = -1;
        wr_cyc   = -1;
        exp_data = '0;
        exp_err  = 1'b0;
        if (bad) begin
          lat     = 2;
          exp_err = 1'b1;
        end else if (!we) begin
          lat      = 3;
          rd_cyc   = cyc + 1;
          exp_data = load_value(w, a % 4, t);
        end else if (t == 3'd2) begin
          lat       = 2;
          wr_cyc    = cyc + 1;
          exp_wword = wd;
        end else begin
          lat       = 4;
          rd_cyc    = cyc + 1;
          wr_cyc    = cyc + 3;
          exp_wword = merge(w, a % 4, t, wd);
        end
        resp_cyc = cyc + int'(lat);
        free_cyc = cyc + int'(lat);
      end
    end
  end

  task automatic preload(input int unsigned idx, input logic [31:0] data);
    bd_addr = idx[ADDR_W-1:0];
    bd_data = data;
    bd_en   = 1'b1;
    @(posedge clk);
    #1 bd_en = 1'b0;
  endtask

  // One request with literal expectations on data, error and accept-to-response latency.
  task automatic req(input string name, input bit is_data, input bit we, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_d,
                     input bit exp_e, input int exp_lat, output int t_acc);
    bit          got;
    int          t_resp;
    logic [31:0] rdata;
    logic        rerr;
    @(posedge clk);
    #1;
    if (is_data) begin
      bus.d_req_we    = we;
      bus.d_req_type  = t;
      bus.d_req_addr  = a;
      bus.d_req_wdata = wd;
      bus.d_req_valid = 1'b1;
    end else begin
      bus.i_req_addr  = a;
      bus.i_req_valid = 1'b1;
    end
    got   = 1'b0;
    t_acc = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (is_data ? bus.d_req_ready : bus.i_req_ready) begin
        got   = 1'b1;
        t_acc = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (is_data) bus.d_req_valid = 1'b0;
    else         bus.i_req_valid = 1'b0;
    check_b({name, "_accept"}, got, 1'b1);
    if (got) begin
      got    = 1'b0;
      t_resp = -1;
      rdata  = '0;
      rerr   = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (is_data ? bus.d_resp_valid : bus.i_resp_valid) begin
          got    = 1'b1;
          t_resp = cyc;
          rdata  = is_data ? bus.d_resp_data : bus.i_resp_data;
          rerr   = is_data ? bus.d_resp_err : bus.i_resp_err;
        end
      end
      check_b({name, "_resp"}, got, 1'b1);
      check({name, "_latency"}, t_resp - t_acc, exp_lat);
      check({name, "_data"}, rdata, exp_d);
      check_b({name, "_err"}, rerr, exp_e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ta, tb, nresp, last_resp;
    bit got;
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    bus.d_req_type  = '0;
    bus.d_req_addr  = '0;
    bus.d_req_wdata = '0;
    bus.mem_rdata   = '0;

    preload(0, 32'h80FF7F01);
    preload(1, 32'h11223344);
    preload(2, 32'h00500093);
    preload(3, 32'hA5A5A5A5);
    preload(4, 32'hDEADBEEF);
    @(posedge clk);
    #1 rst = 1'b0;

    // Simultaneous pair from reset: data wins, fetch is taken in the data response cycle.
    fork
      req("pair1_lw", 1, 0, 3'd2, 32'h10, 0, 32'hDEADBEEF, 0, 3, ta);
      req("pair1_fetch", 0, 0, 3'd2, 32'h8, 0, 32'h00500093, 0, 3, tb);
    join
    check("pair1_order", tb - ta, 3);

    req("lone_lw", 1, 0, 3'd2, 32'h0, 0, 32'h80FF7F01, 0, 3, ta);
    fork
      req("pair2_lw", 1, 0, 3'd2, 32'h10, 0, 32'hDEADBEEF, 0, 3, ta);
      req("pair2_fetch", 0, 0, 3'd2, 32'h8, 0, 32'h00500093, 0, 3, tb);
    join
    check("pair2_order", ta - tb, 3);

    req("lb_1", 1, 0, 3'd0, 32'h1, 0, 32'h0000007F, 0, 3, ta);
    req("lb_3", 1, 0, 3'd0, 32'h3, 0, 32'hFFFFFF80, 0, 3, ta);
    req("lbu_3", 1, 0, 3'd4, 32'h3, 0, 32'h00000080, 0, 3, ta);
    req("lhu_2", 1, 0, 3'd5, 32'h2, 0, 32'h000080FF, 0, 3, ta);
    req("lh_2", 1, 0, 3'd1, 32'h2, 0, 32'hFFFF80FF, 0, 3, ta);
    req("lh_0", 1, 0, 3'd1, 32'h0, 0, 32'h00007F01, 0, 3, ta);

    req("sb_6", 1, 1, 3'd0, 32'h6, 32'h000000AB, 32'h0, 0, 4, ta);
    check("sb_6_word", mem[1], 32'h11AB3344);
    req("lw_4_after_sb", 1, 0, 3'd2, 32'h4, 0, 32'h11AB3344, 0, 3, ta);
    req("sh_6", 1, 1, 3'd1, 32'h6, 32'h1234BEEF, 32'h0, 0, 4, ta);
    req("lw_4_after_sh", 1, 0, 3'd2, 32'h4, 0, 32'hBEEF3344, 0, 3, ta);
    req("sw_4", 1, 1, 3'd2, 32'h4, 32'hCAFEF00D, 32'h0, 0, 2, ta);
    req("lw_4_after_sw", 1, 0, 3'd2, 32'h4, 0, 32'hCAFEF00D, 0, 3, ta);

    req("flt_lw_2", 1, 0, 3'd2, 32'h2, 0, 32'h0, 1, 2, ta);
    req("flt_sh_1", 1, 1, 3'd1, 32'h1, 32'hFFFF, 32'h0, 1, 2, ta);
    req("flt_fetch_6", 0, 0, 3'd2, 32'h6, 0, 32'h0, 1, 2, ta);
    req("flt_lw_range", 1, 0, 3'd2, 32'h00010000, 0, 32'h0, 1, 2, ta);
    req("flt_load_011", 1, 0, 3'd3, 32'h0, 0, 32'h0, 1, 2, ta);
    req("flt_store_100", 1, 1, 3'd4, 32'h0, 0, 32'h0, 1, 2, ta);
    req("fetch_after_flt", 0, 0, 3'd2, 32'h8, 0, 32'h00500093, 0, 3, ta);

    // Reset while an SB is in its read phase: no write and no response may follow.
    @(posedge clk);
    #1;
    bus.d_req_we    = 1'b1;
    bus.d_req_type  = 3'd0;
    bus.d_req_addr  = 32'hC;
    bus.d_req_wdata = 32'h55;
    bus.d_req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.d_req_ready) got = 1'b1;
    end
    check_b("rst_sb_accept", got, 1'b1);
    @(posedge clk);
    #1;
    bus.d_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_b("rst_sb_no_resp", bus.d_resp_valid, 1'b0);
      check_b("rst_sb_no_write", bus.mem_we, 1'b0);
    end
    check("rst_sb_word", mem[3], 32'hA5A5A5A5);
    req("lw_c_after_rst", 1, 0, 3'd2, 32'hC, 0, 32'hA5A5A5A5, 0, 3, ta);

    // Continuous fetch: a response every third cycle.
    @(posedge clk);
    #1;
    bus.i_req_addr  = 32'h8;
    bus.i_req_valid = 1'b1;
    nresp     = 0;
    last_resp = -1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (bus.i_resp_valid) begin
        if (last_resp >= 0) check("stream_gap", cyc - last_resp, 3);
        last_resp = cyc;
        nresp++;
      end
    end
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    check("stream_count", nresp, 4);

    repeat (6) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
